// File: rtl/adc_ctrl_pkg.sv
// Shared constants for the dual-channel ADC capture controller:
// FSM state encoding and channel identifiers.
package adc_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ARMED   = 2'd1;
    localparam state_t ST_CAPTURE = 2'd2;
    localparam state_t ST_DRAIN   = 2'd3;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Stream bundle of the capture controller: two ADC input streams
// and the merged output stream. slave = controller, master = ADC/sink side.
interface adc_capture_ctrl_if #(
    parameter int P_DW = 16
);
    logic [P_DW-1:0] s_axis_ch0_tdata;
    logic            s_axis_ch0_tvalid;
    logic            s_axis_ch0_tready;
    logic [P_DW-1:0] s_axis_ch1_tdata;
    logic            s_axis_ch1_tvalid;
    logic            s_axis_ch1_tready;
    logic [P_DW-1:0] m_axis_tdata;
    logic            m_axis_tuser;
    logic            m_axis_tlast;
    logic            m_axis_tvalid;
    logic            m_axis_tready;

    modport slave (
        input  s_axis_ch0_tdata, s_axis_ch0_tvalid,
        output s_axis_ch0_tready,
        input  s_axis_ch1_tdata, s_axis_ch1_tvalid,
        output s_axis_ch1_tready,
        output m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
        input  m_axis_tready
    );

    modport master (
        output s_axis_ch0_tdata, s_axis_ch0_tvalid,
        input  s_axis_ch0_tready,
        output s_axis_ch1_tdata, s_axis_ch1_tvalid,
        input  s_axis_ch1_tready,
        input  m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
        output m_axis_tready
    );

endinterface

// File: rtl/adc_capture_ctrl_gate.sv
// Per-channel sample gate: decimation, frame counting and a
// one-entry holding register that flags lost samples.
module adc_chan_gate #(
    parameter int P_DW   = 16,
    parameter int P_LENW = 16
) (
    input  logic              aclk,
    input  logic              resetn,
    input  logic              clr,
    input  logic              capture,
    input  logic [7:0]        decim,
    input  logic [P_LENW-1:0] frame_len,
    input  logic              in_valid,
    input  logic [P_DW-1:0]   in_data,
    input  logic              unload,
    output logic              full,
    output logic [P_DW-1:0]   data,
    output logic              count_done,
    output logic              ovf
);

    logic [7:0]        dec_cnt;
    logic [P_LENW-1:0] smp_cnt;
    logic              in_cap;
    logic              keep;
    logic              accept;

    assign count_done = (smp_cnt >= frame_len);
    assign in_cap     = capture & in_valid & ~count_done;
    assign keep       = in_cap & (dec_cnt == 8'd0);
    assign accept     = keep & (~full | unload);
    assign ovf        = keep & full & ~unload & ~clr;

    // Decimate, count kept samples and hold one until the arbiter takes it.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            dec_cnt <= 8'd0;
            smp_cnt <= '0;
            full    <= 1'b0;
            data    <= '0;
        end else if (clr) begin
            dec_cnt <= 8'd0;
            smp_cnt <= '0;
            full    <= 1'b0;
        end else begin
            if (in_cap)
                dec_cnt <= (dec_cnt == decim) ? 8'd0 : dec_cnt + 8'd1;
            if (accept) begin
                full    <= 1'b1;
                data    <= in_data;
                smp_cnt <= smp_cnt + 1'b1;
            end else if (unload) begin
                full    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Dual-channel ADC frame capture: arm/trigger FSM, per-channel gating
// and a round-robin merge into a registered output stream.
module adc_capture_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int P_DW   = 16,
    parameter int P_LENW = 16
) (
    input  logic              aclk,
    input  logic              resetn,
    input  logic [P_LENW-1:0] cfg_frame_len,
    input  logic [7:0]        cfg_decim,
    input  logic              cfg_ext_trig_en,
    input  logic              sw_arm,
    input  logic              ext_trig,
    input  logic              sw_abort,
    adc_capture_ctrl_if.slave axis,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    input  logic              overflow_clr
);

    state_t            state;
    logic [P_LENW-1:0] len_q;
    logic [P_LENW-1:0] len_eff;
    logic [7:0]        decim_q;
    logic              trig_en_q;
    logic              trig_q;
    logic              trig_prev;
    logic              trig_edge;
    logic              start;
    logic              clr;
    logic              capture;
    logic              last_grant;
    logic              sel;
    logic              load_ok;
    logic              any_full;
    logic              rest_full;
    logic              is_last;
    logic              final_hs;
    logic              full0, full1;
    logic              done0, done1;
    logic              ovf0, ovf1;
    logic              unload0, unload1;
    logic [P_DW-1:0]   data0, data1;

    assign axis.s_axis_ch0_tready = resetn;
    assign axis.s_axis_ch1_tready = resetn;

    assign busy      = (state != ST_IDLE);
    assign trig_edge = trig_q & ~trig_prev;
    assign len_eff   = (len_q == '0) ? {{(P_LENW-1){1'b0}}, 1'b1} : len_q;
    assign start     = (state == ST_ARMED) & (~trig_en_q | trig_edge);
    assign clr       = start | sw_abort;
    assign capture   = (state == ST_CAPTURE);

    adc_chan_gate #(.P_DW(P_DW), .P_LENW(P_LENW)) u_gate0 (
        .aclk(aclk), .resetn(resetn), .clr(clr), .capture(capture),
        .decim(decim_q), .frame_len(len_eff),
        .in_valid(axis.s_axis_ch0_tvalid), .in_data(axis.s_axis_ch0_tdata),
        .unload(unload0), .full(full0), .data(data0),
        .count_done(done0), .ovf(ovf0)
    );

    adc_chan_gate #(.P_DW(P_DW), .P_LENW(P_LENW)) u_gate1 (
        .aclk(aclk), .resetn(resetn), .clr(clr), .capture(capture),
        .decim(decim_q), .frame_len(len_eff),
        .in_valid(axis.s_axis_ch1_tvalid), .in_data(axis.s_axis_ch1_tdata),
        .unload(unload1), .full(full1), .data(data1),
        .count_done(done1), .ovf(ovf1)
    );

    assign load_ok   = ~axis.m_axis_tvalid | axis.m_axis_tready;
    assign any_full  = full0 | full1;
    assign unload0   = load_ok & full0 & (sel == CH0);
    assign unload1   = load_ok & full1 & (sel == CH1);
    assign rest_full = (full0 & ~unload0) | (full1 & ~unload1);
    assign is_last   = done0 & done1 & ~rest_full;
    assign final_hs  = (state == ST_DRAIN) & axis.m_axis_tvalid
                     & axis.m_axis_tready & axis.m_axis_tlast;

    // Round-robin pick: on a tie the channel not granted last time wins.
    always_comb begin
        sel = CH0;
        if (full0 & full1)
            sel = (last_grant == CH1) ? CH0 : CH1;
        else if (full1)
            sel = CH1;
    end

    // Capture FSM; abort has priority over every other transition.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else if (sw_abort) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (sw_arm) state <= ST_ARMED;
                ST_ARMED:   if (start) state <= ST_CAPTURE;
                ST_CAPTURE: if (done0 & done1) state <= ST_DRAIN;
                ST_DRAIN:   if (final_hs) state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // Freeze the configuration for the whole frame at arm time.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            len_q     <= '0;
            decim_q   <= 8'd0;
            trig_en_q <= 1'b0;
        end else if ((state == ST_IDLE) & sw_arm & ~sw_abort) begin
            len_q     <= cfg_frame_len;
            decim_q   <= cfg_decim;
            trig_en_q <= cfg_ext_trig_en;
        end
    end

    // Register the trigger level and its previous value for edge detect.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            trig_q    <= 1'b0;
            trig_prev <= 1'b0;
        end else begin
            trig_q    <= ext_trig;
            trig_prev <= trig_q;
        end
    end

    // Output stage: loads a new beat whenever it is empty or draining.
    always_ff @(posedge aclk) begin
        if (!resetn || sw_abort) begin
            axis.m_axis_tvalid <= 1'b0;
            axis.m_axis_tlast  <= 1'b0;
            axis.m_axis_tuser  <= 1'b0;
            axis.m_axis_tdata  <= '0;
        end else if (load_ok) begin
            axis.m_axis_tvalid <= any_full;
            axis.m_axis_tlast  <= any_full & is_last;
            if (any_full) begin
                axis.m_axis_tdata <= (sel == CH1) ? data1 : data0;
                axis.m_axis_tuser <= sel;
            end
        end
    end

    // Remember which channel was granted last; ch1 so ch0 wins first.
    always_ff @(posedge aclk) begin
        if (!resetn)
            last_grant <= CH1;
        else if (load_ok & any_full & ~sw_abort)
            last_grant <= sel;
    end

    // End-of-frame pulse and sticky overflow (a new loss beats a clear).
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= final_hs & ~sw_abort;
            if (ovf0 | ovf1)
                overflow <= 1'b1;
            else if (overflow_clr)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: expected beats are queued
// as stimulus is driven and checked as the output stream hands them over.
module tb_adc_capture_ctrl;

    logic        aclk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] cfg_frame_len = '0;
    logic [7:0]  cfg_decim = '0;
    logic        cfg_ext_trig_en = 1'b0;
    logic        sw_arm = 1'b0;
    logic        ext_trig = 1'b0;
    logic        sw_abort = 1'b0;
    logic        busy, done, overflow;
    logic        overflow_clr = 1'b0;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    logic [17:0] sb[$];
    logic [17:0] exp_beat;

    adc_capture_ctrl_if #(.P_DW(16)) axis ();

    adc_capture_ctrl #(.P_DW(16), .P_LENW(16)) dut (
        .aclk(aclk), .resetn(resetn),
        .cfg_frame_len(cfg_frame_len), .cfg_decim(cfg_decim),
        .cfg_ext_trig_en(cfg_ext_trig_en),
        .sw_arm(sw_arm), .ext_trig(ext_trig), .sw_abort(sw_abort),
        .axis(axis),
        .busy(busy), .done(done), .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 aclk = ~aclk;

    // Output monitor: every handshake must match the head of the queue.
    always @(negedge aclk) begin
        if (done) done_cnt++;
        if (resetn && axis.m_axis_tvalid && axis.m_axis_tready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL beat: unexpected data=%h user=%b last=%b, required no beat",
                         axis.m_axis_tdata, axis.m_axis_tuser, axis.m_axis_tlast);
            end else begin
                exp_beat = sb.pop_front();
                if ({axis.m_axis_tdata, axis.m_axis_tuser, axis.m_axis_tlast} !== exp_beat) begin
                    n_fail++;
                    $display("FAIL beat: got data=%h user=%b last=%b, required data=%h user=%b last=%b",
                             axis.m_axis_tdata, axis.m_axis_tuser, axis.m_axis_tlast,
                             exp_beat[17:2], exp_beat[1], exp_beat[0]);
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic push(logic [15:0] d, logic u, logic l);
        sb.push_back({d, u, l});
    endtask

    task automatic send(logic v0, logic [15:0] d0, logic v1, logic [15:0] d1);
        axis.s_axis_ch0_tvalid = v0;
        axis.s_axis_ch0_tdata  = d0;
        axis.s_axis_ch1_tvalid = v1;
        axis.s_axis_ch1_tdata  = d1;
        tick();
        axis.s_axis_ch0_tvalid = 1'b0;
        axis.s_axis_ch1_tvalid = 1'b0;
    endtask

    task automatic arm(logic [15:0] len, logic [7:0] dec, logic te);
        cfg_frame_len   = len;
        cfg_decim       = dec;
        cfg_ext_trig_en = te;
        sw_arm = 1'b1;
        tick();
        sw_arm = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0 && !busy) break;
            tick();
        end
        tick(2);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        axis.m_axis_tready = 1'b1;
        axis.s_axis_ch0_tvalid = 1'b0;
        axis.s_axis_ch1_tvalid = 1'b0;
        axis.s_axis_ch0_tdata = '0;
        axis.s_axis_ch1_tdata = '0;
        tick(3);
        n_cmp++;
        if ({axis.m_axis_tvalid, axis.m_axis_tlast, axis.m_axis_tuser} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b, required 000",
                     {axis.m_axis_tvalid, axis.m_axis_tlast, axis.m_axis_tuser});
        end
        n_cmp++;
        if (axis.m_axis_tdata !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_tdata: got %h, required 0000", axis.m_axis_tdata);
        end
        n_cmp++;
        if ({busy, done, overflow} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_status: got %b, required 000", {busy, done, overflow});
        end
        n_cmp++;
        if ({axis.s_axis_ch0_tready, axis.s_axis_ch1_tready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_tready: got %b, required 00",
                     {axis.s_axis_ch0_tready, axis.s_axis_ch1_tready});
        end
        resetn = 1'b1;
        tick();
        n_cmp++;
        if ({axis.s_axis_ch0_tready, axis.s_axis_ch1_tready} !== 2'b11) begin
            n_fail++;
            $display("FAIL run_tready: got %b, required 11",
                     {axis.s_axis_ch0_tready, axis.s_axis_ch1_tready});
        end
    endtask

    task automatic test_basic();
        int d0 = done_cnt;
        arm(16'd4, 8'd0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 16'(16'h100 + i), 1'b0, 16'h0);
            push(16'(16'h100 + i), 1'b0, 1'b0);
            send(1'b0, 16'h0, 1'b1, 16'(16'h200 + i));
            push(16'(16'h200 + i), 1'b1, (i == 3));
        end
        wait_empty();
        n_cmp++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain: got pending=%0d busy=%b, required 0 0", sb.size(), busy);
        end
        n_cmp++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL basic_done: got %0d done cycles, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_decim();
        int d0 = done_cnt;
        arm(16'd3, 8'd2, 1'b0);
        tick();
        for (int i = 1; i <= 9; i++) begin
            send(1'b1, 16'(i), 1'b0, 16'h0);
            if ((i - 1) % 3 == 0) push(16'(i), 1'b0, 1'b0);
        end
        for (int j = 0; j < 7; j++) begin
            send(1'b0, 16'h0, 1'b1, 16'(16'h11 + j));
            if (j % 3 == 0) push(16'(16'h11 + j), 1'b1, (j == 6));
        end
        wait_empty();
        n_cmp++;
        if (sb.size() != 0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL decim_end: got pending=%0d busy=%b done=%0d, required 0 0 1",
                     sb.size(), busy, done_cnt - d0);
        end
    endtask

    task automatic test_trigger();
        int d0 = done_cnt;
        ext_trig = 1'b1;
        tick(2);
        arm(16'd1, 8'd0, 1'b1);
        tick(3);
        send(1'b1, 16'hAA, 1'b0, 16'h0);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL trig_armed: got busy=%b, required 1", busy);
        end
        ext_trig = 1'b0;
        tick(2);
        ext_trig = 1'b1;
        tick();
        send(1'b1, 16'hBB, 1'b0, 16'h0);
        send(1'b1, 16'hCC, 1'b0, 16'h0);
        push(16'hCC, 1'b0, 1'b0);
        send(1'b0, 16'h0, 1'b1, 16'hDD);
        push(16'hDD, 1'b1, 1'b1);
        wait_empty();
        n_cmp++;
        if (sb.size() != 0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL trig_end: got pending=%0d busy=%b done=%0d, required 0 0 1",
                     sb.size(), busy, done_cnt - d0);
        end
        ext_trig = 1'b0;
    endtask

    task automatic test_overflow();
        int d0 = done_cnt;
        axis.m_axis_tready = 1'b0;
        arm(16'd3, 8'd0, 1'b0);
        tick();
        send(1'b1, 16'h31, 1'b0, 16'h0);
        push(16'h31, 1'b0, 1'b0);
        send(1'b1, 16'h32, 1'b0, 16'h0);
        push(16'h32, 1'b0, 1'b0);
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_early: got %b, required 0", overflow);
        end
        send(1'b1, 16'h33, 1'b0, 16'h0);
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got %b, required 1", overflow);
        end
        tick(2);
        n_cmp++;
        if (axis.m_axis_tvalid !== 1'b1 || axis.m_axis_tdata !== 16'h31) begin
            n_fail++;
            $display("FAIL ovf_stall: got valid=%b data=%h, required 1 0031",
                     axis.m_axis_tvalid, axis.m_axis_tdata);
        end
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clr: got %b, required 0", overflow);
        end
        axis.m_axis_tready = 1'b1;
        send(1'b1, 16'h34, 1'b0, 16'h0);
        push(16'h34, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            send(1'b0, 16'h0, 1'b1, 16'(16'h41 + j));
            push(16'(16'h41 + j), 1'b1, (j == 2));
        end
        wait_empty();
        n_cmp++;
        if (sb.size() != 0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL ovf_end: got pending=%0d busy=%b done=%0d, required 0 0 1",
                     sb.size(), busy, done_cnt - d0);
        end
    endtask

    task automatic test_abort();
        int d0 = done_cnt;
        arm(16'd2, 8'd0, 1'b0);
        tick();
        axis.m_axis_tready = 1'b0;
        send(1'b1, 16'h51, 1'b1, 16'h61);
        push(16'h51, 1'b0, 1'b0);
        tick();
        axis.m_axis_tready = 1'b1;
        tick();
        axis.m_axis_tready = 1'b0;
        n_cmp++;
        if (axis.m_axis_tvalid !== 1'b1 || axis.m_axis_tdata !== 16'h61) begin
            n_fail++;
            $display("FAIL abort_beat2: got valid=%b data=%h, required 1 0061",
                     axis.m_axis_tvalid, axis.m_axis_tdata);
        end
        sw_abort = 1'b1;
        tick();
        sw_abort = 1'b0;
        n_cmp++;
        if ({axis.m_axis_tvalid, axis.m_axis_tlast, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_clear: got valid/last/busy=%b, required 000",
                     {axis.m_axis_tvalid, axis.m_axis_tlast, busy});
        end
        axis.m_axis_tready = 1'b1;
        tick(4);
        n_cmp++;
        if (done_cnt != d0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL abort_nodone: got done=%0d pending=%0d, required 0 0",
                     done_cnt - d0, sb.size());
        end
        sw_arm = 1'b1;
        sw_abort = 1'b1;
        tick();
        sw_arm = 1'b0;
        sw_abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_vs_arm: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int d0 = done_cnt;
        arm(16'd4, 8'd0, 1'b0);
        tick();
        axis.m_axis_tready = 1'b0;
        send(1'b1, 16'hE1, 1'b1, 16'hE2);
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        n_cmp++;
        if (axis.m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got valid=%b busy=%b, required 0 0",
                     axis.m_axis_tvalid, busy);
        end
        axis.m_axis_tready = 1'b1;
        tick(4);
        n_cmp++;
        if (done_cnt != d0) begin
            n_fail++;
            $display("FAIL rst_mid_done: got %0d done cycles, required 0", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        resetn = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick();
        d0 = done_cnt;
        arm(16'd0, 8'd0, 1'b0);
        tick();
        send(1'b1, 16'h71, 1'b1, 16'h81);
        push(16'h71, 1'b0, 1'b0);
        push(16'h81, 1'b1, 1'b1);
        send(1'b1, 16'h72, 1'b1, 16'h82);
        wait_empty();
        n_cmp++;
        if (sb.size() != 0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL b2b_end: got pending=%0d busy=%b done=%0d, required 0 0 1",
                     sb.size(), busy, done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_decim();
        test_trigger();
        test_overflow();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
